serial_residue_tracker: RTL and testbench

Parametrised successor to the two-bit even/odd serial classifier. Consumes a valid-qualified serial bit stream and tracks (count of 1s mod ONES_MOD, count of 0s mod ZEROS_MOD) as a Moore state. It also presents a one-hot live class vector and, on frame end, a latched per-frame result with a length count. It sits directly behind the serial deserialiser front end and feeds frame-classification logic.

---
 rtl/serial_residue_tracker.sv | 192 +++++++++++++++++++
 tb/tb_serial_residue_tracker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_residue_tracker.sv
// serial_residue_tracker
// Tracks (count of 1s mod ONES_MOD, count of 0s mod ZEROS_MOD) and frame length
// over a valid-qualified serial bit stream. Presents a live one-hot class and,
// at frame end, a latched per-frame result with a saturating length count.
//
// Optional feature macro: TARGET_MATCH_EN
//   When defined, adds tgt_ones/tgt_zeros inputs and a registered res_match output.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, x, in_last      stream bit qualifier, data bit, frame-end marker
//   clr                       synchronous abort of the current frame
//   ones_res, zeros_res       live residues
//   class_onehot              live class, bit = ones_res*ZEROS_MOD + zeros_res
//   res_valid                 one-cycle pulse when result registers update
//   res_ones, res_zeros       final residues of the last frame
//   res_onehot                final class of the last frame (0 = no result yet)
//   res_len, res_len_sat      saturating frame length and its overflow flag
//   tgt_ones, tgt_zeros       (TARGET_MATCH_EN) target residues, sampled at frame end
//   res_match                 (TARGET_MATCH_EN) final residues equal the targets
module serial_residue_tracker #(
    parameter int unsigned ONES_MOD  = 2,
    parameter int unsigned ZEROS_MOD = 2,
    parameter int unsigned LEN_W     = 8,
    localparam int unsigned OW   = (ONES_MOD > 2) ? $clog2(ONES_MOD) : 1,
    localparam int unsigned ZW   = (ZEROS_MOD > 2) ? $clog2(ZEROS_MOD) : 1,
    localparam int unsigned NCLS = ONES_MOD * ZEROS_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             in_last,
    input  logic             clr,
    output logic [OW-1:0]    ones_res,
    output logic [ZW-1:0]    zeros_res,
    output logic [NCLS-1:0]  class_onehot,
    output logic             res_valid,
    output logic [OW-1:0]    res_ones,
    output logic [ZW-1:0]    res_zeros,
    output logic [NCLS-1:0]  res_onehot,
    output logic [LEN_W-1:0] res_len,
    output logic             res_len_sat
`ifdef TARGET_MATCH_EN
    ,
    input  logic [OW-1:0]    tgt_ones,
    input  logic [ZW-1:0]    tgt_zeros,
    output logic             res_match
`endif
);

    // Class index encoding shared by the live and the latched class vectors.
    function automatic logic [NCLS-1:0] class_of(input logic [OW-1:0] o,
                                                 input logic [ZW-1:0] z);
        class_of = NCLS'(1) << (32'(o) * ZEROS_MOD + 32'(z));
    endfunction

    // Running frame state
    logic [OW-1:0]    ones_q,  ones_d;
    logic [ZW-1:0]    zeros_q, zeros_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic             sat_q,   sat_d;
    logic [NCLS-1:0]  class_q, class_d;

    // Frame result state
    logic             rvalid_q,  rvalid_d;
    logic [OW-1:0]    rones_q,   rones_d;
    logic [ZW-1:0]    rzeros_q,  rzeros_d;
    logic [NCLS-1:0]  ronehot_q, ronehot_d;
    logic [LEN_W-1:0] rlen_q,    rlen_d;
    logic             rsat_q,    rsat_d;
`ifdef TARGET_MATCH_EN
    logic             rmatch_q,  rmatch_d;
`endif

    // State after accepting the current bit, before any frame-end clearing
    logic [OW-1:0]    nxt_ones;
    logic [ZW-1:0]    nxt_zeros;
    logic [LEN_W-1:0] nxt_len;
    logic             nxt_sat;

    // Residue and length step: explicit wrap at MOD-1 so non-power-of-two moduli work.
    always_comb begin
        nxt_ones  = ones_q;
        nxt_zeros = zeros_q;
        nxt_len   = len_q;
        nxt_sat   = sat_q;
        if (x) begin
            nxt_ones = (ones_q == OW'(ONES_MOD - 1)) ? '0 : ones_q + OW'(1);
        end else begin
            nxt_zeros = (zeros_q == ZW'(ZEROS_MOD - 1)) ? '0 : zeros_q + ZW'(1);
        end
        if (len_q == '1) begin
            nxt_sat = 1'b1;
        end else begin
            nxt_len = len_q + LEN_W'(1);
        end
    end

    // Next-state selection: clr beats in_valid; frame end latches and restarts.
    always_comb begin
        ones_d    = ones_q;
        zeros_d   = zeros_q;
        len_d     = len_q;
        sat_d     = sat_q;
        rvalid_d  = 1'b0;
        rones_d   = rones_q;
        rzeros_d  = rzeros_q;
        ronehot_d = ronehot_q;
        rlen_d    = rlen_q;
        rsat_d    = rsat_q;
`ifdef TARGET_MATCH_EN
        rmatch_d  = rmatch_q;
`endif
        if (clr) begin
            ones_d  = '0;
            zeros_d = '0;
            len_d   = '0;
            sat_d   = 1'b0;
        end else if (in_valid) begin
            if (in_last) begin
                rvalid_d  = 1'b1;
                rones_d   = nxt_ones;
                rzeros_d  = nxt_zeros;
                ronehot_d = class_of(nxt_ones, nxt_zeros);
                rlen_d    = nxt_len;
                rsat_d    = nxt_sat;
`ifdef TARGET_MATCH_EN
                rmatch_d  = (nxt_ones == tgt_ones) && (nxt_zeros == tgt_zeros);
`endif
                ones_d    = '0;
                zeros_d   = '0;
                len_d     = '0;
                sat_d     = 1'b0;
            end else begin
                ones_d  = nxt_ones;
                zeros_d = nxt_zeros;
                len_d   = nxt_len;
                sat_d   = nxt_sat;
            end
        end
        class_d = class_of(ones_d, zeros_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q    <= '0;
            zeros_q   <= '0;
            len_q     <= '0;
            sat_q     <= 1'b0;
            class_q   <= NCLS'(1);
            rvalid_q  <= 1'b0;
            rones_q   <= '0;
            rzeros_q  <= '0;
            ronehot_q <= '0;
            rlen_q    <= '0;
            rsat_q    <= 1'b0;
`ifdef TARGET_MATCH_EN
            rmatch_q  <= 1'b0;
`endif
        end else begin
            ones_q    <= ones_d;
            zeros_q   <= zeros_d;
            len_q     <= len_d;
            sat_q     <= sat_d;
            class_q   <= class_d;
            rvalid_q  <= rvalid_d;
            rones_q   <= rones_d;
            rzeros_q  <= rzeros_d;
            ronehot_q <= ronehot_d;
            rlen_q    <= rlen_d;
            rsat_q    <= rsat_d;
`ifdef TARGET_MATCH_EN
            rmatch_q  <= rmatch_d;
`endif
        end
    end

    assign ones_res     = ones_q;
    assign zeros_res    = zeros_q;
    assign class_onehot = class_q;
    assign res_valid    = rvalid_q;
    assign res_ones     = rones_q;
    assign res_zeros    = rzeros_q;
    assign res_onehot   = ronehot_q;
    assign res_len      = rlen_q;
    assign res_len_sat  = rsat_q;
`ifdef TARGET_MATCH_EN
    assign res_match    = rmatch_q;
`endif

endmodule

// File: tb/tb_serial_residue_tracker.sv
// Directed bench for serial_residue_tracker. Three instances share one stimulus:
// u0 default (2,2,8), u1 ONES_MOD=3 (3,2,8), u2 short length counter (2,2,3).
module tb_serial_residue_tracker;

    logic clk = 1'b0;
    logic rst, in_valid, x, in_last, clr;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // u0 outputs
    logic       u0_ones, u0_zeros, u0_rv, u0_rones, u0_rzeros, u0_rsat;
    logic [3:0] u0_cls, u0_rcls;
    logic [7:0] u0_rlen;
    // u1 outputs
    logic [1:0] u1_ones, u1_rones;
    logic       u1_zeros, u1_rv, u1_rzeros, u1_rsat;
    logic [5:0] u1_cls, u1_rcls;
    logic [7:0] u1_rlen;
    // u2 outputs
    logic       u2_ones, u2_zeros, u2_rv, u2_rones, u2_rzeros, u2_rsat;
    logic [3:0] u2_cls, u2_rcls;
    logic [2:0] u2_rlen;
`ifdef TARGET_MATCH_EN
    logic       tgt_ones, tgt_zeros, u0_match, u1_match, u2_match;
    logic [1:0] u1_tgt_ones;
`endif

    serial_residue_tracker #(.ONES_MOD(2), .ZEROS_MOD(2), .LEN_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .in_last(in_last), .clr(clr),
        .ones_res(u0_ones), .zeros_res(u0_zeros), .class_onehot(u0_cls),
        .res_valid(u0_rv), .res_ones(u0_rones), .res_zeros(u0_rzeros),
        .res_onehot(u0_rcls), .res_len(u0_rlen), .res_len_sat(u0_rsat)
`ifdef TARGET_MATCH_EN
        , .tgt_ones(tgt_ones), .tgt_zeros(tgt_zeros), .res_match(u0_match)
`endif
    );

    serial_residue_tracker #(.ONES_MOD(3), .ZEROS_MOD(2), .LEN_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .in_last(in_last), .clr(clr),
        .ones_res(u1_ones), .zeros_res(u1_zeros), .class_onehot(u1_cls),
        .res_valid(u1_rv), .res_ones(u1_rones), .res_zeros(u1_rzeros),
        .res_onehot(u1_rcls), .res_len(u1_rlen), .res_len_sat(u1_rsat)
`ifdef TARGET_MATCH_EN
        , .tgt_ones(u1_tgt_ones), .tgt_zeros(tgt_zeros), .res_match(u1_match)
`endif
    );

    serial_residue_tracker #(.ONES_MOD(2), .ZEROS_MOD(2), .LEN_W(3)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .in_last(in_last), .clr(clr),
        .ones_res(u2_ones), .zeros_res(u2_zeros), .class_onehot(u2_cls),
        .res_valid(u2_rv), .res_ones(u2_rones), .res_zeros(u2_rzeros),
        .res_onehot(u2_rcls), .res_len(u2_rlen), .res_len_sat(u2_rsat)
`ifdef TARGET_MATCH_EN
        , .tgt_ones(tgt_ones), .tgt_zeros(tgt_zeros), .res_match(u2_match)
`endif
    );

    // Drive one cycle of inputs on the falling edge, return just after the rising edge.
    task automatic step(input logic v, input logic b, input logic last, input logic c);
        @(negedge clk);
        in_valid = v; x = b; in_last = last; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; x = 1'b0; in_last = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scenario-1 stream: 1,1,0,1,0,0,0,1,1 with in_last on the ninth bit.
    task automatic send_frame_s1();
        logic seq [9];
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) step(1'b1, seq[i], (i == 8), 1'b0);
    endtask

    // n ones with in_last on the final bit.
    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, (i == n - 1), 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (u0_ones !== 1'b0) begin n_bad++; $display("FAIL reset_ones got %0h want 0", u0_ones); end
        n_cmp++; if (u0_zeros !== 1'b0) begin n_bad++; $display("FAIL reset_zeros got %0h want 0", u0_zeros); end
        n_cmp++; if (u0_cls !== 4'b0001) begin n_bad++; $display("FAIL reset_class got %b want 0001", u0_cls); end
        n_cmp++; if (u0_rv !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %0h want 0", u0_rv); end
        n_cmp++; if (u0_rcls !== 4'b0000) begin n_bad++; $display("FAIL reset_res_onehot got %b want 0000", u0_rcls); end
        n_cmp++; if (u0_rlen !== 8'd0) begin n_bad++; $display("FAIL reset_res_len got %0d want 0", u0_rlen); end
        n_cmp++; if (u0_rsat !== 1'b0) begin n_bad++; $display("FAIL reset_res_len_sat got %0h want 0", u0_rsat); end
        n_cmp++; if (u1_cls !== 6'b000001) begin n_bad++; $display("FAIL reset_class_u1 got %b want 000001", u1_cls); end
    endtask

    task automatic test_default_frame();
        logic       seq [9];
        logic [3:0] exp_cls [9];
        do_reset();
        seq     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_cls = '{4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0100,
                    4'b1000, 4'b0100, 4'b0001, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, seq[i], (i == 8), 1'b0);
            n_cmp++; if (u0_cls !== exp_cls[i]) begin n_bad++; $display("FAIL s1_live_class[%0d] got %b want %b", i, u0_cls, exp_cls[i]); end
            n_cmp++; if (u0_rv !== (i == 8)) begin n_bad++; $display("FAIL s1_res_valid[%0d] got %0h want %0h", i, u0_rv, (i == 8)); end
        end
        n_cmp++; if (u0_rones !== 1'b1) begin n_bad++; $display("FAIL s1_res_ones got %0h want 1", u0_rones); end
        n_cmp++; if (u0_rzeros !== 1'b0) begin n_bad++; $display("FAIL s1_res_zeros got %0h want 0", u0_rzeros); end
        n_cmp++; if (u0_rcls !== 4'b0100) begin n_bad++; $display("FAIL s1_res_onehot got %b want 0100", u0_rcls); end
        n_cmp++; if (u0_rlen !== 8'd9) begin n_bad++; $display("FAIL s1_res_len got %0d want 9", u0_rlen); end
        n_cmp++; if (u0_rsat !== 1'b0) begin n_bad++; $display("FAIL s1_res_len_sat got %0h want 0", u0_rsat); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (u0_rv !== 1'b0) begin n_bad++; $display("FAIL s1_pulse_width got %0h want 0", u0_rv); end
        n_cmp++; if (u0_rlen !== 8'd9) begin n_bad++; $display("FAIL s1_res_held got %0d want 9", u0_rlen); end
    endtask

    task automatic test_gaps_mod3();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);   // gap with x=1 and in_last=1 must be ignored
        n_cmp++; if (u1_ones !== 2'd1 || u1_zeros !== 1'b0) begin n_bad++; $display("FAIL gap_hold got %0d/%0d want 1/0", u1_ones, u1_zeros); end
        n_cmp++; if (u1_rv !== 1'b0) begin n_bad++; $display("FAIL gap_no_result got %0h want 0", u1_rv); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (u1_ones !== 2'd1) begin n_bad++; $display("FAIL mod3_wrap got %0d want 1", u1_ones); end
        n_cmp++; if (u1_cls !== 6'b000100) begin n_bad++; $display("FAIL mod3_live_class got %b want 000100", u1_cls); end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (u1_rv !== 1'b1) begin n_bad++; $display("FAIL mod3_res_valid got %0h want 1", u1_rv); end
        n_cmp++; if (u1_rones !== 2'd1) begin n_bad++; $display("FAIL mod3_res_ones got %0d want 1", u1_rones); end
        n_cmp++; if (u1_rzeros !== 1'b1) begin n_bad++; $display("FAIL mod3_res_zeros got %0d want 1", u1_rzeros); end
        n_cmp++; if (u1_rcls !== 6'b001000) begin n_bad++; $display("FAIL mod3_res_onehot got %b want 001000", u1_rcls); end
        n_cmp++; if (u1_rlen !== 8'd7) begin n_bad++; $display("FAIL mod3_res_len got %0d want 7", u1_rlen); end
    endtask

    task automatic test_len_sat();
        do_reset();
        send_ones(7);
        n_cmp++; if (u2_rlen !== 3'd7 || u2_rsat !== 1'b0) begin n_bad++; $display("FAIL len7 got %0d/%0h want 7/0", u2_rlen, u2_rsat); end
        send_ones(8);
        n_cmp++; if (u2_rlen !== 3'd7 || u2_rsat !== 1'b1) begin n_bad++; $display("FAIL len8 got %0d/%0h want 7/1", u2_rlen, u2_rsat); end
        send_ones(10);
        n_cmp++; if (u2_rlen !== 3'd7 || u2_rsat !== 1'b1) begin n_bad++; $display("FAIL len10 got %0d/%0h want 7/1", u2_rlen, u2_rsat); end
        n_cmp++; if (u2_rones !== 1'b0) begin n_bad++; $display("FAIL len10_ones got %0h want 0", u2_rones); end
        send_ones(2);
        n_cmp++; if (u2_rlen !== 3'd2 || u2_rsat !== 1'b0) begin n_bad++; $display("FAIL len2_after_sat got %0d/%0h want 2/0", u2_rlen, u2_rsat); end
        n_cmp++; if (u0_rlen !== 8'd2) begin n_bad++; $display("FAIL len2_wide got %0d want 2", u0_rlen); end
    endtask

    task automatic test_clr();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (u0_rcls !== 4'b1000 || u0_rlen !== 8'd2) begin n_bad++; $display("FAIL clr_prior got %b/%0d want 1000/2", u0_rcls, u0_rlen); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);   // clr beats in_last
        n_cmp++; if (u0_rv !== 1'b0) begin n_bad++; $display("FAIL clr_no_result got %0h want 0", u0_rv); end
        n_cmp++; if (u0_cls !== 4'b0001 || u0_ones !== 1'b0 || u0_zeros !== 1'b0) begin n_bad++; $display("FAIL clr_live got %b want 0001", u0_cls); end
        n_cmp++; if (u0_rcls !== 4'b1000 || u0_rlen !== 8'd2) begin n_bad++; $display("FAIL clr_held got %b/%0d want 1000/2", u0_rcls, u0_rlen); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (u0_rlen !== 8'd2) begin n_bad++; $display("FAIL clr_held2 got %0d want 2", u0_rlen); end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (u0_rv !== 1'b1) begin n_bad++; $display("FAIL clr_res_valid got %0h want 1", u0_rv); end
        n_cmp++; if (u0_rones !== 1'b1 || u0_rzeros !== 1'b0) begin n_bad++; $display("FAIL clr_res got %0h/%0h want 1/0", u0_rones, u0_rzeros); end
        n_cmp++; if (u0_rcls !== 4'b0100 || u0_rlen !== 8'd3) begin n_bad++; $display("FAIL clr_res2 got %b/%0d want 0100/3", u0_rcls, u0_rlen); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; x = 1'b1; in_last = 1'b1; clr = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (u0_cls !== 4'b0001 || u0_ones !== 1'b0 || u0_zeros !== 1'b0) begin n_bad++; $display("FAIL rstmid_live got %b want 0001", u0_cls); end
        n_cmp++; if (u0_rv !== 1'b0) begin n_bad++; $display("FAIL rstmid_res_valid got %0h want 0", u0_rv); end
        n_cmp++; if (u0_rcls !== 4'b0000 || u0_rlen !== 8'd0 || u0_rones !== 1'b0) begin n_bad++; $display("FAIL rstmid_res got %b/%0d want 0000/0", u0_rcls, u0_rlen); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (u0_rv !== 1'b0) begin n_bad++; $display("FAIL rstmid_after got %0h want 0", u0_rv); end
    endtask

    task automatic test_back_to_back();
        logic       bits [3];
        logic [3:0] exp_r [3];
        bits  = '{1'b1, 1'b0, 1'b1};
        exp_r = '{4'b0100, 4'b0010, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bits[i], 1'b1, 1'b0);
            n_cmp++; if (u0_rv !== 1'b1 || u0_rlen !== 8'd1) begin n_bad++; $display("FAIL b2b[%0d] got %0h/%0d want 1/1", i, u0_rv, u0_rlen); end
            n_cmp++; if (u0_rcls !== exp_r[i] || u0_cls !== 4'b0001) begin n_bad++; $display("FAIL b2b_class[%0d] got %b/%b want %b/0001", i, u0_rcls, u0_cls, exp_r[i]); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (u0_rv !== 1'b0) begin n_bad++; $display("FAIL b2b_end got %0h want 0", u0_rv); end
    endtask

    task automatic test_target();
`ifdef TARGET_MATCH_EN
        do_reset();
        n_cmp++; if (u0_match !== 1'b0) begin n_bad++; $display("FAIL match_reset got %0h want 0", u0_match); end
        tgt_ones = 1'b1; tgt_zeros = 1'b0;
        send_frame_s1();
        n_cmp++; if (u0_match !== 1'b1) begin n_bad++; $display("FAIL match_hit got %0h want 1", u0_match); end
        tgt_zeros = 1'b1;
        send_frame_s1();
        n_cmp++; if (u0_match !== 1'b0) begin n_bad++; $display("FAIL match_miss got %0h want 0", u0_match); end
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = 1'b0; in_last = 1'b0; clr = 1'b0;
`ifdef TARGET_MATCH_EN
        tgt_ones = 1'b0; tgt_zeros = 1'b0; u1_tgt_ones = 2'd0;
`endif
        test_reset();
        test_default_frame();
        test_gaps_mod3();
        test_len_sat();
        test_clr();
        test_reset_mid();
        test_back_to_back();
        test_target();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
